// File: rtl/lcd_ctrl.sv
// HD44780 character LCD write controller.
// Turns a toggle-handshaked CPU register write into a timed RS/DATA setup,
// EN strobe, hold and command-execution wait. o_busy covers the whole sequence.
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 12,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_lcd,
  output logic        o_busy,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data
);

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_tgl;
  logic               pending;
  logic               capture;
  logic               is_clr;
  logic               unused_io_bits;

  // A zero-length phase still occupies one cycle; the counter holds cycles-1.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
    if (cyc == 0) return '0;
    return CNT_W'(cyc - 1);
  endfunction

  assign pending        = (i_io_lcd[11] != acc_tgl);
  assign o_lcd_rw       = 1'b0;
  assign unused_io_bits = ^{i_io_lcd[30:12], i_io_lcd[9:8]};

  // Clear display / return home run much longer inside the LCD than other writes.
  assign is_clr = !o_lcd_rs &&
                  ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02) || (o_lcd_data == 8'h03));

  // Next-state and counter reload: each phase loads its length on entry and counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          capture = 1'b1;
          state_d = SETUP;
          cnt_d   = cyc_load(SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = cyc_load(EN_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = cyc_load(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
          cnt_d   = is_clr ? cyc_load(CLR_WAIT_CYC) : cyc_load(WAIT_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, handshake and registered LCD pins; EN/BUSY decode the next state
  // so they are glitch-free flops aligned with the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_tgl    <= 1'b0;
      o_busy     <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_data <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_busy   <= (state_d != IDLE);
      o_lcd_en <= (state_d == PULSE);
      o_lcd_on <= i_io_lcd[31];
      if (capture) begin
        acc_tgl    <= i_io_lcd[11];
        o_lcd_rs   <= i_io_lcd[10];
        o_lcd_data <= i_io_lcd[7:0];
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus pushes expected transfers, a monitor
// measures each busy window on the falling clock edge and compares.
module tb_lcd_ctrl;

  localparam int SETUP = 2;
  localparam int ENC   = 4;
  localparam int HOLD  = 2;
  localparam int WAITC = 10;
  localparam int CLRW  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io = 32'h0;
  logic        o_busy, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0]  o_lcd_data;

  lcd_ctrl #(
    .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
    .WAIT_CYC(WAITC), .CLR_WAIT_CYC(CLRW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_io_lcd(io),
    .o_busy(o_busy), .o_lcd_on(o_lcd_on), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_len;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_total = 0;
  logic tgl = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flip the request toggle and present a new write; optionally expect it to complete.
  task automatic start_xfer(input logic rs, input logic [7:0] data, input int busy_len,
                            input bit expect_it);
    exp_t x;
    tgl = ~tgl;
    io  = {io[31], 19'b0, tgl, rs, 2'b00, data};
    if (expect_it) begin
      x.rs = rs; x.data = data; x.busy_len = busy_len;
      exp_q.push_back(x);
    end
  endtask

  task automatic flip_only();
    tgl    = ~tgl;
    io[11] = tgl;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check({name, "_timeout"}, 1, 0);
  endtask

  // Monitor: one record per busy window, compared against the head of the queue.
  logic in_xfer = 0, prev_en = 0;
  int   busy_len, en_len, en_pulses, en_start;
  logic cap_rs;
  logic [7:0] cap_data;

  always @(negedge clk) begin
    if (o_lcd_en && !prev_en) en_total++;
    if (!rst_n) begin
      in_xfer = 0; busy_len = 0; en_len = 0; en_pulses = 0; en_start = -1;
      prev_en = 0;
    end else begin
      if (o_busy) begin
        if (!in_xfer) begin
          in_xfer = 1; busy_len = 0; en_len = 0; en_pulses = 0; en_start = -1;
          cap_rs = o_lcd_rs; cap_data = o_lcd_data;
        end
        if (o_lcd_en && !prev_en) begin
          en_pulses++;
          en_start = busy_len;
        end
        if (o_lcd_en) en_len++;
        busy_len++;
      end else if (in_xfer) begin
        in_xfer = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_rs", cap_rs, e.rs);
          check("xfer_data", cap_data, e.data);
          check("xfer_busy_len", busy_len, e.busy_len);
          check("xfer_en_len", en_len, ENC);
          check("xfer_en_pulses", en_pulses, 1);
          check("xfer_en_start", en_start, SETUP);
          check("xfer_data_hold", {o_lcd_rs, o_lcd_data}, {cap_rs, cap_data});
        end
      end
      prev_en = o_lcd_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_len;
  } vec_t;

  vec_t vecs[7];
  int   en0;

  initial begin
    vecs[0] = '{1'b0, 8'h01, 28};
    vecs[1] = '{1'b0, 8'h02, 28};
    vecs[2] = '{1'b0, 8'h03, 28};
    vecs[3] = '{1'b1, 8'h01, 18};
    vecs[4] = '{1'b0, 8'h04, 18};
    vecs[5] = '{1'b0, 8'h00, 18};
    vecs[6] = '{1'b1, 8'h02, 18};

    // Reset state
    #3;
    check("reset_outputs", {o_busy, o_lcd_on, o_lcd_rs, o_lcd_en, o_lcd_data}, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {o_busy, o_lcd_on, o_lcd_rs, o_lcd_en, o_lcd_data}, 12'h000);
    check("rw_zero", o_lcd_rw, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Data write 0x8000_0C41
    io[31] = 1'b1;
    start_xfer(1'b1, 8'h41, 18, 1);
    check("io_word", io, 32'h8000_0C41);
    @(posedge clk); #1;
    check("capture_rs_data", {o_lcd_rs, o_lcd_data}, 9'h141);
    check("capture_busy", o_busy, 1);
    check("lcd_on", o_lcd_on, 1);
    wait_idle("t1");
    @(posedge clk); #1;

    // Clear/home vs ordinary wait selection
    for (int i = 0; i < 7; i++) begin
      start_xfer(vecs[i].rs, vecs[i].data, vecs[i].busy_len, 1);
      @(posedge clk); #1;
      wait_idle("table");
      @(posedge clk); #1;
    end

    // Request queued during WAIT starts one cycle after busy falls
    start_xfer(1'b1, 8'h50, 18, 1);
    repeat (10) @(posedge clk);
    #1;
    start_xfer(1'b1, 8'h42, 18, 1);
    wait_idle("b2b_first");
    @(negedge clk);
    check("b2b_restart_busy", o_busy, 1);
    check("b2b_restart_data", o_lcd_data, 8'h42);
    wait_idle("b2b_second");
    @(posedge clk); #1;

    // Two flips during one busy window cancel
    en0 = en_total;
    start_xfer(1'b1, 8'h33, 18, 1);
    repeat (3) @(posedge clk);
    #1; flip_only();
    repeat (9) @(posedge clk);
    #1; flip_only();
    wait_idle("double_flip");
    repeat (5) @(negedge clk);
    check("double_flip_idle", o_busy, 0);
    check("double_flip_pulses", en_total - en0, 1);
    @(posedge clk); #1;

    // Reset during PULSE aborts asynchronously and the transfer does not resume
    start_xfer(1'b1, 8'h77, 0, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (o_lcd_en) begin
          seen = 1;
          break;
        end
      end
      check("abort_en_seen", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_en_async", o_lcd_en, 0);
    check("abort_busy_async", o_busy, 0);
    check("abort_data_async", o_lcd_data, 8'h00);
    tgl = 1'b0;
    io[11] = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    en0 = en_total;
    repeat (40) @(negedge clk);
    check("abort_no_pulse", en_total - en0, 0);
    check("abort_no_busy", o_busy, 0);
    check("abort_lcd_on_back", o_lcd_on, 1);

    // Power bit alone: one-cycle latency, no strobe
    @(posedge clk); #1;
    en0 = en_total;
    io[31] = 1'b0;
    @(negedge clk);
    check("on_latency_old", o_lcd_on, 1);
    @(posedge clk); #1;
    check("on_latency_new", o_lcd_on, 0);
    io[31] = 1'b1;
    @(negedge clk);
    check("on_latency_old2", o_lcd_on, 0);
    @(posedge clk); #1;
    check("on_latency_new2", o_lcd_on, 1);
    repeat (3) @(negedge clk);
    check("on_no_en", en_total - en0, 0);
    check("on_no_busy", o_busy, 0);

    // Toggle already set at reset release starts a transfer on the first edge
    @(posedge clk); #1;
    rst_n = 1'b0;
    tgl = 1'b0;
    start_xfer(1'b1, 8'h55, 18, 1);
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_start_busy", o_busy, 1);
    check("release_start_data", {o_lcd_rs, o_lcd_data}, 9'h155);
    wait_idle("release");
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL provide parameter SETUP_CYC, default 2: cycles RS/DATA are stable before EN rises.
REQ-002 SHALL provide parameter EN_CYC, default 12: cycles EN is held high.
REQ-003 SHALL provide parameter HOLD_CYC, default 2: cycles RS/DATA are held after EN falls.
REQ-004 SHALL provide parameter WAIT_CYC, default 2000: post-transfer execution wait for ordinary commands and data.
REQ-005 SHALL provide parameter CLR_WAIT_CYC, default 82000: post-transfer wait for clear/home commands.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports i_clk and i_rst_n.
REQ-007 Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_io_lcd  in  32  CPU LCD register from the LSU: [31] display power, [11] request toggle, [10] RS, [7:0] data; other bits are ignored.
- o_busy  out  1  transfer in progress, readable by software through the switch/status path.
- o_lcd_on  out  1  LCD power/backlight enable.
- o_lcd_rs  out  1  HD44780 register select.
- o_lcd_rw  out  1  HD44780 read/write, tied to 0.
- o_lcd_en  out  1  HD44780 enable strobe.
- o_lcd_data  out  8  HD44780 data bus.

Function
REQ-008 SHALL implement an FSM with states IDLE, SETUP, PULSE, HOLD and WAIT, plus a single down/up counter of at least 17 bits.
REQ-009 SHALL hold an internal accepted-toggle bit, acc_tgl; a request is pending when i_io_lcd[11] != acc_tgl.
REQ-010 In IDLE with a request pending, at the clock edge:
- acc_tgl <= i_io_lcd[11];
- i_io_lcd[10] and i_io_lcd[7:0] are latched into o_lcd_rs and o_lcd_data;
- the FSM enters SETUP and o_busy becomes 1.
REQ-011 Timing per state:
- SETUP lasts exactly SETUP_CYC cycles with o_lcd_en=0.
- PULSE lasts exactly EN_CYC cycles with o_lcd_en=1.
- HOLD lasts exactly HOLD_CYC cycles with o_lcd_en=0.
- WAIT lasts exactly N cycles, after which the FSM returns to IDLE and o_busy drops to 0.
REQ-012 N SHALL be CLR_WAIT_CYC when the latched RS=0 and latched data is 0x01, 0x02 or 0x03; otherwise N is WAIT_CYC.
REQ-013 o_busy SHALL be high for exactly SETUP_CYC+EN_CYC+HOLD_CYC+N consecutive cycles per transfer.
REQ-014 o_lcd_rs and o_lcd_data SHALL change only at request capture and otherwise hold their last latched value, including in IDLE.
REQ-015 o_lcd_en SHALL be registered and glitch-free, high only in PULSE.
REQ-016 A toggle change while busy SHALL NOT affect the current transfer.
REQ-017 A request still pending on return to IDLE SHALL start a transfer on the next edge, using i_io_lcd contents sampled at that edge.
REQ-018 Two toggle flips while busy cancel each other: no transfer occurs, by design.
REQ-019 o_lcd_on SHALL be a register updated from i_io_lcd[31] every cycle, independent of FSM state (1-cycle latency).
REQ-020 o_lcd_rw SHALL be constant 0.
REQ-021 The counter SHALL saturate-free reload on every state entry; a zero-valued parameter SHALL be treated as 1 cycle.
REQ-022 Back-to-back transfers SHALL have a minimum gap of 1 IDLE cycle (o_busy low for at least 1 cycle).

Reset
REQ-023 While i_rst_n=0: FSM=IDLE, counter=0, acc_tgl=0, and o_busy, o_lcd_on, o_lcd_rs, o_lcd_en and o_lcd_data are all 0, asynchronously.
REQ-024 Reset mid-transfer SHALL drop o_lcd_en immediately without waiting for a clock edge; the aborted transfer SHALL NOT resume.
REQ-025 After reset release, if i_io_lcd[11]=1 a request is pending and a transfer starts at the first edge.

Verification (SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, WAIT_CYC=10, CLR_WAIT_CYC=20)
REQ-026 Write i_io_lcd=0x8000_0C41 from IDLE ->
- o_lcd_rs=1 and o_lcd_data=0x41 next cycle;
- o_lcd_en high for exactly 4 cycles, starting 2 cycles after capture;
- o_busy high for exactly 18 cycles;
- o_lcd_on=1.
REQ-027 Write i_io_lcd=0x0000_0801 (clear) -> o_lcd_rs=0, o_lcd_data=0x01, o_busy high for exactly 28 cycles.
REQ-028 Flip bit 11 once, with data 0x42, during WAIT of a transfer -> second transfer starts 1 cycle after o_busy falls, with o_lcd_data=0x42.
REQ-029 Flip bit 11 twice during one busy window -> exactly one EN pulse is observed in total.
REQ-030 Assert i_rst_n=0 mid-PULSE -> o_lcd_en=0 and o_busy=0 before the next edge; after release with bit 11=0, no EN pulse occurs.
REQ-031 Toggle bit 31 without touching bit 11 -> o_lcd_on follows with 1-cycle latency, and o_lcd_en stays 0.
